// File: rtl/mem_port_arbiter.sv
// Shares one request/valid memory port between instruction fetch and data access.
// Optional wait timeout with bus error pulse: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_mask,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

  state_e      state_q, state_d;
  // Side of the current/most recent grant; 1 = fetch. Also steers the response.
  logic        last_fetch_q, last_fetch_d;
  logic        we_q, we_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        busy, grant, done, timeout_hit;

  assign busy  = (state_q == StFetch) || (state_q == StData);
  assign grant = (state_q == StIdle) && (if_req || dm_req);
  assign done  = busy && (mem_valid || timeout_hit);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant) begin
      wait_cnt_d = '0;
    end else if (busy) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // A response arriving on the last allowed cycle still completes normally.
  assign timeout_hit = busy && !mem_valid && (wait_cnt_q == WaitLast);
  assign err_d       = timeout_hit;
  assign bus_err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_fetch_q <= 1'b1;
      we_q         <= 1'b0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      we_q         <= we_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (if_req && dm_req) begin
          state_d = last_fetch_q ? StData : StFetch;
        end else if (if_req) begin
          state_d = StFetch;
        end else if (dm_req) begin
          state_d = StData;
        end
      end
      StFetch, StData: begin
        if (done) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_fetch_d = last_fetch_q;
    we_d         = we_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if (grant && (state_d == StFetch)) begin
      last_fetch_d = 1'b1;
      we_d         = 1'b0;
      mask_d       = 4'hF;
      addr_d       = if_addr;
      wdata_d      = '0;
    end else if (grant && (state_d == StData)) begin
      last_fetch_d = 1'b0;
      we_d         = dm_we;
      mask_d       = dm_mask;
      addr_d       = dm_addr;
      wdata_d      = dm_wdata;
    end
    if (done) begin
      if (last_fetch_q) begin
        if_rdata_d = mem_valid ? mem_rdata : '0;
      end else begin
        dm_rdata_d = mem_valid ? mem_rdata : '0;
      end
    end
  end

  always_comb begin
    mem_request = busy;
    mem_we_re   = we_q;
    mem_mask    = mask_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    if_rdata    = if_rdata_q;
    dm_rdata    = dm_rdata_q;
    if_valid    = (state_q == StResp) && last_fetch_q;
    dm_valid    = (state_q == StResp) && !last_fetch_q;
    stall       = (if_req || dm_req) && !(if_valid || dm_valid);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model
// plus directed scenarios pinning latency, arbitration order, reset and timeout.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int  TbTimeout = 4;
  localparam bit  ToEn      = 1'b1;
`else
  localparam int  TbTimeout = 255;
  localparam bit  ToEn      = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid;
  logic [3:0]  dm_mask;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_request, mem_we_re, mem_valid;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, bus_err;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT(TbTimeout)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_mask(dm_mask), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding transaction, a response cycle, then a free port.
  int          m_side;        // -1 none, 0 fetch, 1 data
  int          m_last;        // side granted most recently
  int          m_wait;
  bit          m_resp, m_resp_err;
  int          m_resp_side;
  logic        x_we;
  logic [3:0]  x_mask;
  logic [31:0] x_addr, x_wdata, m_if_rdata, m_dm_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_side = -1; m_last = 0; m_wait = 0;
    m_resp = 1'b0; m_resp_err = 1'b0; m_resp_side = 0;
    m_if_rdata = '0; m_dm_rdata = '0;
  endtask

  task automatic model_finish(input logic [31:0] data, input bit err);
    m_resp = 1'b1; m_resp_err = err; m_resp_side = m_side;
    if (m_side == 0) m_if_rdata = data;
    else             m_dm_rdata = data;
    m_side = -1;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (m_resp) begin
      m_resp = 1'b0; m_resp_err = 1'b0;
    end else if (m_side >= 0) begin
      if (mem_valid)                          model_finish(mem_rdata, 1'b0);
      else if (ToEn && m_wait == TbTimeout-1) model_finish(32'h0, 1'b1);
      else                                    m_wait++;
    end else if (if_req || dm_req) begin
      if (if_req && dm_req) m_side = (m_last == 0) ? 1 : 0;
      else                  m_side = if_req ? 0 : 1;
      m_last = m_side; m_wait = 0;
      if (m_side == 0) begin
        x_we = 1'b0; x_mask = 4'hF; x_addr = if_addr; x_wdata = 32'h0;
      end else begin
        x_we = dm_we; x_mask = dm_mask; x_addr = dm_addr; x_wdata = dm_wdata;
      end
    end
  endtask

  task automatic check_model();
    bit exp_ifv, exp_dmv;
    exp_ifv = m_resp && (m_resp_side == 0);
    exp_dmv = m_resp && (m_resp_side == 1);
    chk("mem_request", 32'(mem_request), 32'(m_side >= 0));
    if (m_side >= 0) begin
      chk("mem_we_re", 32'(mem_we_re), 32'(x_we));
      chk("mem_mask", 32'(mem_mask), 32'(x_mask));
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_wdata", mem_wdata, x_wdata);
    end
    chk("if_valid", 32'(if_valid), 32'(exp_ifv));
    chk("dm_valid", 32'(dm_valid), 32'(exp_dmv));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("bus_err", 32'(bus_err), 32'(m_resp && m_resp_err));
    chk("stall", 32'(stall), 32'((if_req || dm_req) && !(exp_ifv || exp_dmv)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic zero_outputs_check(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_dm_valid"}, 32'(dm_valid), 32'h0);
    chk({tag, "_mem_request"}, 32'(mem_request), 32'h0);
    chk({tag, "_mem_we_re"}, 32'(mem_we_re), 32'h0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    chk({tag, "_mem_mask"}, 32'(mem_mask), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle, held over two edges; mv drives mem_valid meanwhile.
  task automatic do_reset(input bit mv);
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_valid = mv;
    #1;
    zero_outputs_check("rst");
    repeat (2) @(posedge clk);
    #1;
    zero_outputs_check("rst_hold");
    rst = 1'b0; mem_valid = 1'b0;
    model_reset();
    settle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tie_addr [4];
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_mask = '0; dm_addr = '0; dm_wdata = '0; mem_valid = 1'b0; mem_rdata = '0;
    model_reset();
    do_reset(1'b0);

    // Fetch only, zero-wait memory.
    tick(); if_req = 1'b1; if_addr = 32'h100; settle();
    chk("t1_stall_req", 32'(stall), 32'h1);
    tick(); mem_valid = 1'b1; mem_rdata = 32'h0050_0093; settle();
    chk("t1_mem_request", 32'(mem_request), 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_mask", 32'(mem_mask), 32'hF);
    chk("t1_mem_we_re", 32'(mem_we_re), 32'h0);
    tick(); mem_valid = 1'b0; if_req = 1'b0; settle();
    chk("t1_if_valid", 32'(if_valid), 32'h1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_mem_request_off", 32'(mem_request), 32'h0);
    tick(); settle();

    // Store with three wait cycles.
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_mask = 4'b1100; dm_addr = 32'h2004;
    dm_wdata = 32'hABCD_0000; settle();
    for (int c = 1; c <= 4; c++) begin
      tick(); mem_valid = (c == 4); mem_rdata = 32'h5555_AAAA; settle();
      chk("t2_mem_request", 32'(mem_request), 32'h1);
      chk("t2_mem_we_re", 32'(mem_we_re), 32'h1);
      chk("t2_mem_addr", mem_addr, 32'h2004);
      chk("t2_mem_mask", 32'(mem_mask), 32'hC);
      chk("t2_mem_wdata", mem_wdata, 32'hABCD_0000);
      chk("t2_stall", 32'(stall), 32'h1);
    end
    tick(); mem_valid = 1'b0; settle();
    chk("t2_dm_valid", 32'(dm_valid), 32'h1);
    chk("t2_stall_off", 32'(stall), 32'h0);
    dm_req = 1'b0;
    tick(); settle();

    // Simultaneous requests alternate sides; data wins the first tie after reset.
    do_reset(1'b0);
    tie_addr[0] = 32'h300; tie_addr[1] = 32'h200; tie_addr[2] = 32'h304; tie_addr[3] = 32'h204;
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_mask = 4'hF;
    dm_addr = 32'h300; settle();
    for (int k = 0; k < 4; k++) begin
      tick(); mem_valid = 1'b1; mem_rdata = 32'h1111_1111 * (k + 1); settle();
      chk("t3_grant_addr", mem_addr, tie_addr[k]);
      tick(); mem_valid = 1'b0; settle();
      chk("t3_valid_side", {31'h0, if_valid}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k == 0) dm_addr = 32'h304;
      if (k == 1) if_addr = 32'h204;
      if (k == 2) dm_req = 1'b0;
      if (k == 3) if_req = 1'b0;
      tick(); settle();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: timeout response after TbTimeout waiting cycles.
    if_req = 1'b1; if_addr = 32'h500; settle();
    for (int c = 0; c < TbTimeout; c++) begin
      tick(); settle();
      chk("t5_mem_request", 32'(mem_request), 32'h1);
      chk("t5_bus_err_low", 32'(bus_err), 32'h0);
    end
    tick(); if_req = 1'b0; settle();
    chk("t5_bus_err", 32'(bus_err), 32'h1);
    chk("t5_if_valid", 32'(if_valid), 32'h1);
    chk("t5_if_rdata", if_rdata, 32'h0);
    tick(); settle();
    chk("t5_idle", 32'(mem_request), 32'h0);
`endif

    // Reset during a data transaction with the response arriving under reset.
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_mask = 4'h3; settle();
    tick(); settle();
    chk("t4_in_data", 32'(mem_request), 32'h1);
    do_reset(1'b1);
    tick(); settle();
    chk("t4_no_dm_valid", 32'(dm_valid), 32'h0);
    chk("t4_idle", 32'(mem_request), 32'h0);

    // Stray mem_valid while idle is ignored.
    tick(); mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; settle();
    tick(); mem_valid = 1'b0; settle();
    chk("t6_if_valid", 32'(if_valid), 32'h0);
    chk("t6_dm_valid", 32'(dm_valid), 32'h0);
    chk("t6_if_rdata", if_rdata, 32'h0);
    chk("t6_dm_rdata", dm_rdata, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (if_req) begin
        if (m_resp && m_resp_side == 0) begin
          if ($urandom_range(0, 1) == 0) if_req = 1'b0;
          else if_addr = $urandom & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (dm_req) begin
        if (m_resp && m_resp_side == 1) begin
          if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
          else begin dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom); end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom); dm_mask = 4'($urandom);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_valid = (m_side >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      mem_rdata = $urandom;
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
